// File: rtl/evt_burst_gen_pkg.sv
// Shared types and defaults for the event burst generator.
// State encoding and default counter width used by the top and its interface.
package evt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } burst_state_t;

    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/evt_burst_gen_if.sv
// Control/status bundle between a burst requester (master) and evt_burst_gen (slave).
// Plain wires; no handshake beyond start/abort pulses and the busy/done status.
interface evt_burst_gen_if
    import evt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
);

    logic             start_in;
    logic [CNT_W-1:0] count_in;
    logic [CNT_W-1:0] period_in;
    logic             abort_in;
    logic             evt_out;
    logic             busy_out;
    logic             done_out;
    logic [CNT_W-1:0] sent_out;

    modport master (
        output start_in, count_in, period_in, abort_in,
        input  evt_out, busy_out, done_out, sent_out
    );

    modport slave (
        input  start_in, count_in, period_in, abort_in,
        output evt_out, busy_out, done_out, sent_out
    );

endinterface

// File: rtl/evt_burst_gen_period_timer.sv
// Loadable down-counter that spaces strobes; zero_out is high while the count sits at 0.
// Load takes effect on the next edge; counting stops at 0 until reloaded.
module evt_period_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_in,
    input  logic [CNT_W-1:0] value_in,
    output logic             zero_out
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt <= '0;
        end else if (load_in) begin
            cnt <= value_in;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero_out = (cnt == '0);

endmodule

// File: rtl/evt_burst_gen.sv
// Emits a programmed burst of single-cycle strobes at a fixed period, then a done strobe.
// First strobe one cycle after an accepted start; start is ignored while busy or finishing.
module evt_burst_gen
    import evt_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEFAULT,
    parameter int MIN_PERIOD = 1
) (
    input  logic            clk_in,
    input  logic            rst_in,
    evt_burst_gen_if.slave  bus
);

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

    burst_state_t     state;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] remain_q;
    logic [CNT_W-1:0] sent_q;
    logic             evt_q;
    logic             busy_q;
    logic             done_q;

    logic [CNT_W-1:0] period_clamped;
    logic             start_ok;
    logic             strobe_due;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_zero;

    always_comb begin
        period_clamped = (bus.period_in < MIN_P) ? MIN_P : bus.period_in;
        start_ok       = (state == IDLE) && bus.start_in;
        strobe_due     = (state == RUN) && !bus.abort_in && timer_zero && (remain_q != '0);
        timer_load     = (start_ok && (bus.count_in != '0)) || strobe_due;
        // The timer holds P-1 after a strobe so the next one lands exactly P cycles later.
        timer_value    = start_ok ? (period_clamped - 1'b1) : (period_q - 1'b1);
    end

    evt_period_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .load_in  (timer_load),
        .value_in (timer_value),
        .zero_out (timer_zero)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            period_q <= '0;
            remain_q <= '0;
            sent_q   <= '0;
            evt_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    evt_q  <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start_in) begin
                        sent_q   <= '0;
                        period_q <= period_clamped;
                        if (bus.count_in == '0) begin
                            state  <= FINISH;
                            done_q <= 1'b1;
                        end else begin
                            state    <= RUN;
                            busy_q   <= 1'b1;
                            evt_q    <= 1'b1;
                            sent_q   <= CNT_W'(1);
                            remain_q <= bus.count_in - 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.abort_in) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        evt_q  <= 1'b0;
                    end else if (remain_q == '0) begin
                        // Last strobe was emitted in the current cycle.
                        state  <= FINISH;
                        busy_q <= 1'b0;
                        evt_q  <= 1'b0;
                        done_q <= 1'b1;
                    end else if (strobe_due) begin
                        evt_q    <= 1'b1;
                        sent_q   <= sent_q + 1'b1;
                        remain_q <= remain_q - 1'b1;
                    end else begin
                        evt_q <= 1'b0;
                    end
                end
                FINISH: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    evt_q  <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.evt_out  = evt_q;
    assign bus.busy_out = busy_q;
    assign bus.done_out = done_q;
    assign bus.sent_out = sent_q;

endmodule

// File: tb/tb_evt_burst_gen.sv
// Directed bench for evt_burst_gen with a schedule-based burst model checked every cycle.
module tb_evt_burst_gen;
    import evt_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    evt_burst_gen_if #(.CNT_W(W)) bus();

    evt_burst_gen #(
        .CNT_W      (W),
        .MIN_PERIOD (1)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int cyc      = 0;
    int cur_test = 0;
    bit run_en   = 1'b0;
    int errors   = 0;
    int checks   = 0;

    // Model: the current burst as a schedule (start cycle, count, period, abort cut).
    bit m_valid = 1'b0;
    bit m_abort = 1'b0;
    int m_s = 0;
    int m_n = 0;
    int m_p = 1;
    int m_cut = 0;

    function automatic int m_last();
        return m_s + 1 + (m_n - 1) * m_p;
    endfunction

    function automatic int m_end();
        if (!m_valid) return -1000;
        if (m_n == 0) return m_s + 1;
        if (m_abort)  return m_cut;
        return m_last() + 1;
    endfunction

    function automatic void model_at(input int x, output int e_evt, output int e_busy,
                                     output int e_done, output int e_sent);
        int lim;
        int upto;
        e_evt = 0; e_busy = 0; e_done = 0; e_sent = 0;
        if (m_valid && x > m_s) begin
            if (m_n == 0) begin
                e_done = (x == m_s + 1) ? 1 : 0;
            end else begin
                lim    = m_abort ? m_cut : m_last();
                upto   = (x < lim) ? x : lim;
                e_sent = (upto - m_s - 1) / m_p + 1;
                e_busy = (x <= lim) ? 1 : 0;
                e_evt  = (x <= lim && ((x - m_s - 1) % m_p) == 0) ? 1 : 0;
                e_done = (!m_abort && x == m_last() + 1) ? 1 : 0;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int e_evt, e_busy, e_done, e_sent;
        if (run_en) begin
            if (cyc >= 1) begin
                model_at(cyc, e_evt, e_busy, e_done, e_sent);
                chk($sformatf("t%0d c%0d evt",  cur_test, cyc), 32'(bus.evt_out),  e_evt);
                chk($sformatf("t%0d c%0d busy", cur_test, cyc), 32'(bus.busy_out), e_busy);
                chk($sformatf("t%0d c%0d done", cur_test, cyc), 32'(bus.done_out), e_done);
                chk($sformatf("t%0d c%0d sent", cur_test, cyc), 32'(bus.sent_out), e_sent);

                // Hand-derived anchors from the burst timing rules.
                if (cur_test == 0 && cyc == 1)  chk("lit t0 reset sent", 32'(bus.sent_out), 0);
                if (cur_test == 0 && cyc == 15) chk("lit t0 evt@15",  32'(bus.evt_out),  1);
                if (cur_test == 0 && cyc == 19) chk("lit t0 busy@19", 32'(bus.busy_out), 1);
                if (cur_test == 0 && cyc == 20) chk("lit t0 done@20", 32'(bus.done_out), 1);
                if (cur_test == 0 && cyc == 25) chk("lit t0 sent@25", 32'(bus.sent_out), 3);
                if (cur_test == 1 && cyc == 14) chk("lit t1 evt@14",  32'(bus.evt_out),  1);
                if (cur_test == 1 && cyc == 15) chk("lit t1 done@15", 32'(bus.done_out), 1);
                if (cur_test == 2 && cyc == 12) chk("lit t2 evt@12",  32'(bus.evt_out),  1);
                if (cur_test == 2 && cyc == 15) chk("lit t2 done@15", 32'(bus.done_out), 1);
                if (cur_test == 3 && cyc == 11) chk("lit t3 done@11", 32'(bus.done_out), 1);
                if (cur_test == 3 && cyc == 11) chk("lit t3 busy@11", 32'(bus.busy_out), 0);
                if (cur_test == 4 && cyc == 19) chk("lit t4 evt@19",  32'(bus.evt_out),  1);
                if (cur_test == 4 && cyc == 20) chk("lit t4 done@20", 32'(bus.done_out), 1);
                if (cur_test == 4 && cyc == 21) chk("lit t4 evt@21",  32'(bus.evt_out),  0);
                if (cur_test == 5 && cyc == 14) chk("lit t5 evt@14",  32'(bus.evt_out),  1);
                if (cur_test == 5 && cyc == 17) chk("lit t5 evt@17",  32'(bus.evt_out),  0);
                if (cur_test == 5 && cyc == 17) chk("lit t5 busy@17", 32'(bus.busy_out), 0);
                if (cur_test == 5 && cyc == 30) chk("lit t5 sent@30", 32'(bus.sent_out), 2);
                if (cur_test == 6 && cyc == 13) chk("lit t6 evt@13",  32'(bus.evt_out),  1);
                if (cur_test == 6 && cyc == 14) chk("lit t6 busy@14", 32'(bus.busy_out), 0);
                if (cur_test == 6 && cyc == 14) chk("lit t6 sent@14", 32'(bus.sent_out), 0);
                if (cur_test == 6 && cyc == 21) chk("lit t6 evt@21",  32'(bus.evt_out),  1);
                if (cur_test == 6 && cyc == 22) chk("lit t6 done@22", 32'(bus.done_out), 1);
                if (cur_test == 7 && cyc == 15) chk("lit t7 done@15", 32'(bus.done_out), 0);
                if (cur_test == 7 && cyc == 15) chk("lit t7 sent@15", 32'(bus.sent_out), 2);
                if (cur_test == 7 && cyc == 16) chk("lit t7 evt@16",  32'(bus.evt_out),  1);
                if (cur_test == 7 && cyc == 21) chk("lit t7 done@21", 32'(bus.done_out), 1);
            end

            // Fold this cycle's inputs into the schedule (they act from the next cycle).
            if (rst) begin
                m_valid = 1'b0;
                m_abort = 1'b0;
            end else if (bus.start_in && cyc > m_end()) begin
                m_valid = 1'b1;
                m_abort = 1'b0;
                m_s     = cyc;
                m_n     = int'(bus.count_in);
                m_p     = (bus.period_in == 0) ? 1 : int'(bus.period_in);
            end else if (bus.abort_in && m_valid && m_n > 0 && !m_abort &&
                         cyc >= m_s + 1 && cyc <= m_last()) begin
                m_abort = 1'b1;
                m_cut   = cyc;
            end
        end
    end

    task automatic st(input int n, input int p);
        bus.start_in  = 1'b1;
        bus.count_in  = W'(n);
        bus.period_in = W'(p);
    endtask

    task automatic drive(input int t, input int c);
        bus.start_in  = 1'b0;
        bus.abort_in  = 1'b0;
        bus.count_in  = W'($urandom);
        bus.period_in = W'($urandom);
        rst = (c < 2);
        case (t)
            0: if (c == 10) st(3, 4);
            1: if (c == 10) st(4, 1);
            2: if (c == 10) st(4, 0);
            3: if (c == 10) st(0, 5);
            4: begin
                if (c == 10) st(2, 8);
                if (c == 13) st(9, 1);
                if (c == 20) st(1, 1);
                if (c == 25) bus.abort_in = 1'b1;
            end
            5: begin
                if (c == 10) st(5, 3);
                if (c == 16) bus.abort_in = 1'b1;
            end
            6: begin
                if (c == 10) st(5, 2);
                if (c == 13) rst = 1'b1;
                if (c == 20) st(1, 3);
            end
            7: begin
                if (c == 5)  bus.abort_in = 1'b1;
                if (c == 10) st(2, 3);
                if (c == 14) bus.abort_in = 1'b1;
                if (c == 15) begin
                    st(3, 2);
                    bus.abort_in = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        bus.start_in  = 1'b0;
        bus.abort_in  = 1'b0;
        bus.count_in  = '0;
        bus.period_in = '0;
        rst    = 1'b1;
        run_en = 1'b1;
        for (int t = 0; t < 8; t++) begin
            for (int c = 0; c < 40; c++) begin
                @(posedge clk);
                cur_test = t;
                cyc      = c;
                #1;
                drive(t, c);
            end
        end
        @(negedge clk);
        #1;
        run_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
